// File: rtl/npu_sram_pkg.sv
// Shared types and constants for the NPU weight SRAM (sram_B) path.
// Used by the sram_B arbiter, its interface and its grant logic.
package npu_sram_pkg;

  localparam int SRAM_ADDR_W  = 10;
  localparam int SRAM_DATA_W  = 8;

  localparam int PORT_LOADER  = 0;
  localparam int PORT_COMPUTE = 1;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_b_arbiter_if.sv
// Two-port requester bundle for the sram_B arbiter.
// master = requesters, slave = arbiter.
interface sram_b_arbiter_if
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) ();

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant with a bounded burst streak.
// Grant is combinational from valid and the owner/streak state.
module sram_rr_arb2
  import npu_sram_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] gnt,
  output logic       idx
);

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  owner_e     owner, owner_n, pick;
  logic [3:0] streak, streak_n;

  // owner and streak register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= OWN0;
      streak <= '0;
    end else begin
      owner  <= owner_n;
      streak <= streak_n;
    end
  end

  // pick a port, then advance the streak
  always_comb begin
    pick     = owner;
    owner_n  = owner;
    streak_n = streak;
    gnt      = 2'b00;
    unique case (1'b1)
      (valid == 2'b01): pick = OWN0;
      (valid == 2'b10): pick = OWN1;
      (valid == 2'b11 && streak >= MAXB):
        pick = (owner == OWN0) ? OWN1 : OWN0;
      default: pick = owner;
    endcase
    if (valid == 2'b00) begin
      streak_n = '0;
    end else begin
      gnt     = (pick == OWN1) ? 2'b10 : 2'b01;
      owner_n = pick;
      if (pick != owner)
        streak_n = 4'd1;
      else if (streak < MAXB)
        streak_n = streak + 4'd1;
    end
  end

  assign idx = (pick == OWN1);

endmodule

// File: rtl/sram_b_arbiter.sv
// sram_B sharing between loader (port 0) and compute (port 1).
// Fire -> registered SRAM issue -> response strobe two cycles later.
module sram_b_arbiter
  import npu_sram_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  sram_b_arbiter_if.slave   bus,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  logic [1:0] gnt;
  logic       idx;
  logic       fire;
  logic       iss_tag;
  logic       rsp_tag;
  logic       rsp_pend;
  sram_req_t  req0, req1, sel;

  assign req0 = '{
    we:    bus.req_we[PORT_LOADER],
    addr:  bus.req_addr[PORT_LOADER*ADDR_W +: ADDR_W],
    wdata: bus.req_wdata[PORT_LOADER*DATA_W +: DATA_W]
  };
  assign req1 = '{
    we:    bus.req_we[PORT_COMPUTE],
    addr:  bus.req_addr[PORT_COMPUTE*ADDR_W +: ADDR_W],
    wdata: bus.req_wdata[PORT_COMPUTE*DATA_W +: DATA_W]
  };

  sram_rr_arb2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.req_valid),
    .gnt   (gnt),
    .idx   (idx)
  );

  assign sel           = idx ? req1 : req0;
  assign fire          = |gnt;
  assign bus.req_ready = gnt;

  // issue stage: drive the SRAM from the granted request
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      iss_tag  <= 1'b0;
    end else begin
      mem_ce <= fire;
      mem_we <= fire & sel.we;
      if (fire) begin
        mem_addr <= sel.addr;
        mem_din  <= sel.wdata;
        iss_tag  <= idx;
      end
    end
  end

  // response stage: SRAM dout is valid the cycle after issue
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend <= 1'b0;
      rsp_tag  <= 1'b0;
    end else begin
      rsp_pend <= mem_ce;
      rsp_tag  <= iss_tag;
    end
  end

  assign bus.rsp_valid = {rsp_pend & rsp_tag, rsp_pend & ~rsp_tag};
  assign bus.rsp_rdata = mem_dout;
  assign busy          = mem_ce | rsp_pend;

endmodule

// File: tb/tb_sram_b_arbiter.sv
// Directed bench for sram_b_arbiter with a behavioural sram_B.
// Expected values are hand-computed per step.
module tb_sram_b_arbiter;
  import npu_sram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ce, mem_we, busy;
  logic [9:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] mem [1024];
  logic [1:0] g [10];
  int         ncmp = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  sram_b_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  sram_b_arbiter #(
    .ADDR_W(10), .DATA_W(8), .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // synchronous read-before-write SRAM model
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16]  = 8'h11;
    mem[32]  = 8'h22;
    mem_dout = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_ce) begin
        mem_dout <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_din;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    tick;
    tick;
    settle;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rspv", 32'(bus.rsp_valid), 32'h0);
    chk("rst_ce", 32'(mem_ce), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", 32'(mem_din), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick;
    rst = 1'b0;

    // 1: port 0 write then port 1 read of the same address
    drive(2'b01, 2'b01, 10'h005, 10'h000, 8'hA5, 8'h00);
    settle;
    chk("t1_gnt0", 32'(bus.req_ready), 32'h1);
    tick;
    drive(2'b10, 2'b00, 10'h005, 10'h005, 8'hA5, 8'h00);
    settle;
    chk("t1_gnt1", 32'(bus.req_ready), 32'h2);
    chk("t1_ce", 32'(mem_ce), 32'h1);
    chk("t1_we", 32'(mem_we), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h005);
    chk("t1_din", 32'(mem_din), 32'hA5);
    tick;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t1_ack0", 32'(bus.rsp_valid), 32'h1);
    chk("t1_ack0_rd", 32'(bus.rsp_rdata), 32'h00);
    chk("t1_rd_we", 32'(mem_we), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    tick;
    settle;
    chk("t1_rsp1", 32'(bus.rsp_valid), 32'h2);
    chk("t1_rsp1_rd", 32'(bus.rsp_rdata), 32'hA5);
    chk("t1_ce_off", 32'(mem_ce), 32'h0);
    tick;
    settle;
    chk("t1_idle_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_addr_hold", 32'(mem_addr), 32'h005);

    // 2: both ports streaming reads, burst of 4
    do_reset;
    for (int i = 0; i < 10; i++)
      g[i] = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
    drive(2'b11, 2'b00, 10'h010, 10'h020, 8'h0, 8'h0);
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("t2_gnt%0d", i), 32'(bus.req_ready), 32'(g[i]));
      if (i >= 1) chk($sformatf("t2_ce%0d", i), 32'(mem_ce), 32'h1);
      if (i >= 2) begin
        chk($sformatf("t2_rspv%0d", i), 32'(bus.rsp_valid), 32'(g[i-2]));
        chk($sformatf("t2_rd%0d", i), 32'(bus.rsp_rdata),
            (g[i-2] == 2'b01) ? 32'h11 : 32'h22);
      end
      tick;
    end
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t2_tail8", 32'(bus.rsp_valid), 32'(g[8]));
    tick;
    settle;
    chk("t2_tail9", 32'(bus.rsp_valid), 32'(g[9]));
    tick;
    settle;
    chk("t2_tail_idle", 32'(bus.rsp_valid), 32'h0);

    // 3: only port 1 valid for 10 cycles
    drive(2'b10, 2'b00, 10'h000, 10'h020, 8'h0, 8'h0);
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("t3_gnt%0d", i), 32'(bus.req_ready), 32'h2);
      if (i >= 1) chk($sformatf("t3_ce%0d", i), 32'(mem_ce), 32'h1);
      if (i >= 2) begin
        chk($sformatf("t3_rspv%0d", i), 32'(bus.rsp_valid), 32'h2);
        chk($sformatf("t3_rd%0d", i), 32'(bus.rsp_rdata), 32'h22);
      end
      tick;
    end
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t3_ce_last", 32'(mem_ce), 32'h1);
    tick;
    settle;
    chk("t3_ce_end", 32'(mem_ce), 32'h0);
    tick;
    settle;
    chk("t3_drained", 32'(busy), 32'h0);

    // 4: back-to-back writes to 0x3FF, then read
    drive(2'b01, 2'b01, 10'h3FF, 10'h000, 8'h3C, 8'h00);
    settle;
    chk("t4_gnt", 32'(bus.req_ready), 32'h1);
    tick;
    drive(2'b01, 2'b01, 10'h3FF, 10'h000, 8'h7E, 8'h00);
    settle;
    tick;
    drive(2'b01, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00);
    settle;
    chk("t4_ack1", 32'(bus.rsp_valid), 32'h1);
    chk("t4_ack1_rd", 32'(bus.rsp_rdata), 32'h00);
    tick;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t4_ack2", 32'(bus.rsp_valid), 32'h1);
    chk("t4_ack2_rbw", 32'(bus.rsp_rdata), 32'h3C);
    tick;
    settle;
    chk("t4_rd", 32'(bus.rsp_valid), 32'h1);
    chk("t4_rd_data", 32'(bus.rsp_rdata), 32'h7E);
    tick;

    // 5: reset right after a port 0 read fires
    drive(2'b01, 2'b00, 10'h005, 10'h000, 8'h00, 8'h00);
    settle;
    chk("t5_gnt", 32'(bus.req_ready), 32'h1);
    tick;
    rst = 1'b1;
    drive(2'b10, 2'b00, 10'h000, 10'h020, 8'h00, 8'h00);
    settle;
    chk("t5_issue", 32'(mem_ce), 32'h1);
    tick;
    rst = 1'b0;
    drive(2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00);
    settle;
    chk("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("t5_ce", 32'(mem_ce), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_first", 32'(bus.req_ready), 32'h1);
    tick;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t5_ce2", 32'(mem_ce), 32'h1);
    tick;
    settle;
    chk("t5_rsp", 32'(bus.rsp_valid), 32'h1);
    chk("t5_rsp_rd", 32'(bus.rsp_rdata), 32'h11);
    tick;
    tick;

    // 6: port 0 waits while port 1 holds the burst
    drive(2'b10, 2'b00, 10'h000, 10'h020, 8'h00, 8'h00);
    tick;
    tick;
    drive(2'b11, 2'b00, 10'h3FF, 10'h020, 8'h00, 8'h00);
    settle;
    chk("t6_wait0", 32'(bus.req_ready), 32'h2);
    tick;
    settle;
    chk("t6_wait1", 32'(bus.req_ready), 32'h2);
    tick;
    settle;
    chk("t6_gnt0", 32'(bus.req_ready), 32'h1);
    tick;
    drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0);
    settle;
    chk("t6_ce", 32'(mem_ce), 32'h1);
    chk("t6_addr", 32'(mem_addr), 32'h3FF);
    chk("t6_we", 32'(mem_we), 32'h0);
    tick;
    settle;
    chk("t6_rsp", 32'(bus.rsp_valid), 32'h1);
    chk("t6_rsp_rd", 32'(bus.rsp_rdata), 32'h7E);
    tick;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/sram_b_arbiter.md
Name: sram_b_arbiter

Overview:
- Shares the single-port 1024x8 weight SRAM (sram_B) between two requesters: port 0 is the DMA/host loader, port 1 is the compute-engine operand fetch.
- Each port uses a valid/ready request channel and a fixed-latency response strobe.
- Arbitration is round-robin with a bounded burst streak, so the compute engine can stream reads without starving the loader.
- The SRAM control signals are registered, and the block drives sram_B's ce/we/addr/din directly.

Parameters:
ADDR_W, 10, SRAM address width (1024 entries)
DATA_W, 8, SRAM data width
MAX_BURST, 4, max consecutive grants to one port while the other port is waiting (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port grant; a transfer fires on valid&&ready
req_we  in  2  per-port write enable
req_addr  in  2*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  per-port write data
rsp_valid  out  2  per-port response strobe
rsp_rdata  out  DATA_W  response data, shared by both ports and qualified by rsp_valid
mem_ce  out  1  to sram_B ce
mem_we  out  1  to sram_B we
mem_addr  out  ADDR_W  to sram_B addr
mem_din  out  DATA_W  to sram_B din
mem_dout  in  DATA_W  from sram_B dout
busy  out  1  a request is in the issue or response stage

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values are all 0: req_ready, rsp_valid, mem_ce, mem_we, mem_addr, mem_din, busy, the streak counter and the owner. The round-robin pointer resets to favour port 0.
- Grant is combinational from req_valid and the registered arbitration state. req_ready is one-hot or zero, and at most one transfer fires per cycle.
- Arbitration FSM, state = owner (OWN0, OWN1) plus streak counter streak (0..MAX_BURST):
  - Only one port valid: grant it. If it equals the owner, streak++ (saturating); otherwise owner switches and streak=1.
  - Both valid, owner's streak < MAX_BURST: grant the owner, streak++.
  - Both valid, streak == MAX_BURST: grant the other port, owner switches, streak=1.
  - Neither valid: no grant, streak=0, owner held.
  - Out of reset, owner=OWN0 and streak=0; with both ports valid, port 0 wins first.
- Issue stage, cycle N+1 after a fire at cycle N:
  - mem_ce=1.
  - mem_we, mem_addr and mem_din are taken from the granted port.
  - A tag register records the port index.
- With no fire, mem_ce=0 and mem_we=0. mem_addr and mem_din hold their last value.
- Response stage, cycle N+2:
  - rsp_valid[tag]=1 for exactly one cycle, for both reads and writes (a write is acknowledged).
  - rsp_rdata = mem_dout, passed through combinationally.
  - On a write, rsp_rdata is the pre-write contents (read-before-write).
- Fixed latency is 2 cycles from fire to rsp_valid. The block accepts one transfer per cycle with no bubbles, and responses return in grant order.
- Read after write to the same address, fired on consecutive cycles: the read returns the new data, because the SRAM write commits before the following read.
- busy = mem_ce | any rsp_valid-stage pending.
- Reset mid-operation: in-flight issue and response stages are dropped. No rsp_valid is generated for them, and mem_ce=0 on the cycle after rst is sampled.
- req_valid must stay asserted with its payload stable until ready; this is a requester obligation. The block does not check it.
- Address wrap does not exist: the full ADDR_W range is legal.

Decomposition:
- Shared package npu_sram_pkg:
  - SRAM_ADDR_W=10, SRAM_DATA_W=8
  - PORT_LOADER=0, PORT_COMPUTE=1
  - enum owner_e {OWN0, OWN1}
  - packed struct sram_req_t {we, addr, wdata}
- One sub-module: sram_rr_arb2, the 2-way round-robin grant logic with the streak counter and MAX_BURST parameter. The top level adds the issue/response pipeline and the tag register.

Test Plan:
1. Reset, then port 0 writes addr 0x005 data 0xA5 followed by a port 1 read of 0x005 -> mem_we pulses with addr 0x005 din 0xA5; rsp_valid[0] two cycles after its fire; rsp_valid[1] two cycles after its fire with rsp_rdata=0xA5.
2. Both ports hold valid continuously with reads, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0...; no idle cycles; responses in the same order at +2.
3. Only port 1 valid for 10 cycles -> 10 back-to-back grants to port 1 (no forced switch); streak saturates at 4; mem_ce high for 10 consecutive cycles.
4. Write 0x3C to addr 0x3FF, then on the next cycle write 0x7E to 0x3FF -> second ack has rsp_rdata=0x3C (read-before-write); a subsequent read returns 0x7E.
5. Assert rst on the cycle after a port 0 read fires -> no rsp_valid appears; mem_ce=0, busy=0 next cycle; the first grant after reset goes to port 0 when both are valid.
6. Port 0 valid with req_ready low due to port 1 owning the burst -> port 0 request held stable; granted within MAX_BURST cycles; its payload is issued unchanged.
